// File: rtl/jump_resolve_if.sv
// Signal bundle between the jump resolver, the jump unit/issue side, fetch and the writeback arbiter.
// master drives issue/result/accept inputs; slave is the resolver itself.
interface jump_resolve_if #(
  parameter int CNT_W = 16
);
  logic             issue_en;
  logic             issue_is_branch;
  logic [4:0]       issue_rd;
  logic             fu_finish;
  logic             fu_cmp_res;
  logic [31:0]      fu_PC_jump;
  logic [31:0]      fu_PC_wb;
  logic             busy;
  logic             redirect;
  logic [31:0]      redirect_PC;
  logic             misalign;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             wb_ready;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output issue_en, issue_is_branch, issue_rd,
    output fu_finish, fu_cmp_res, fu_PC_jump, fu_PC_wb,
    output wb_ready,
    input  busy, redirect, redirect_PC, misalign,
    input  wb_valid, wb_rd, wb_data,
    input  branch_cnt, taken_cnt, dbg_state
  );

  modport slave (
    input  issue_en, issue_is_branch, issue_rd,
    input  fu_finish, fu_cmp_res, fu_PC_jump, fu_PC_wb,
    input  wb_ready,
    output busy, redirect, redirect_PC, misalign,
    output wb_valid, wb_rd, wb_data,
    output branch_cnt, taken_cnt, dbg_state
  );
endinterface

// File: rtl/jump_resolve.sv
// Resolves jump/branch results: one-cycle redirect/misalign pulse, held link writeback, branch counters.
// Writeback handshake: wb_valid/wb_rd/wb_data hold steady until a cycle with wb_ready high completes it.
module jump_resolve #(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  jump_resolve_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESOLVE = 2'd2,
    S_WB      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             is_branch_q;
  logic [4:0]       rd_q;
  logic             cmp_q;
  logic [31:0]      pc_jump_q;
  logic [31:0]      pc_wb_q;
  logic             busy_q;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      redirect_pc_q;
  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_data_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             taken;
  logic             aligned;
  logic             load_wb;

  always_comb begin
    state_d      = state_q;
    redirect_d   = 1'b0;
    misalign_d   = 1'b0;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    taken        = ~is_branch_q | cmp_q;
    aligned      = (pc_jump_q[1:0] == 2'b00);
    unique case (state_q)
      S_IDLE: begin
        if (bus.issue_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fu_finish) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        redirect_d = taken & aligned;
        misalign_d = taken & ~aligned;
        if (is_branch_q) begin
          branch_cnt_d = branch_cnt_q + CNT_W'(1);
          taken_cnt_d  = taken_cnt_q + CNT_W'(cmp_q);
        end
        // Only an aligned JAL/JALR with a real destination produces a link write.
        if (!is_branch_q && aligned && (rd_q != 5'd0)) state_d = S_WB;
        else                                            state_d = S_IDLE;
      end
      S_WB: begin
        if (bus.wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    load_wb = (state_q == S_RESOLVE) && (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      is_branch_q   <= 1'b0;
      rd_q          <= 5'd0;
      cmp_q         <= 1'b0;
      pc_jump_q     <= 32'd0;
      pc_wb_q       <= 32'd0;
      busy_q        <= 1'b0;
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != S_IDLE);
      redirect_q   <= redirect_d;
      misalign_q   <= misalign_d;
      wb_valid_q   <= (state_d == S_WB);
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      if ((state_q == S_IDLE) && bus.issue_en) begin
        is_branch_q <= bus.issue_is_branch;
        rd_q        <= bus.issue_rd;
      end
      if ((state_q == S_WAIT) && bus.fu_finish) begin
        cmp_q     <= bus.fu_cmp_res;
        pc_jump_q <= bus.fu_PC_jump;
        pc_wb_q   <= bus.fu_PC_wb;
      end
      if (redirect_d) redirect_pc_q <= pc_jump_q;
      if (load_wb) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= pc_wb_q;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_PC = redirect_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.taken_cnt   = taken_cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_jump_resolve.sv
// Directed bench for jump_resolve: vector table of resolved jumps plus reset and counter-wrap sequences.
module tb_jump_resolve;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  jump_resolve_if #(.CNT_W(CNT_W)) bus ();

  jump_resolve #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_branch;
    logic [4:0]  rd;
    logic        cmp;
    logic [31:0] pc_jump;
    logic [31:0] pc_wb;
    int          wait_cyc;
    logic        exp_redirect;
    logic        exp_misalign;
    logic        exp_wb;
  } vec_t;

  int              tests;
  int              fails;
  logic [CNT_W-1:0] exp_branch;
  logic [CNT_W-1:0] exp_taken;
  vec_t            vecs[8];
  vec_t            tb_vec;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"},        32'(bus.busy), 32'd0);
    chk({tag, " redirect"},    32'(bus.redirect), 32'd0);
    chk({tag, " misalign"},    32'(bus.misalign), 32'd0);
    chk({tag, " wb_valid"},    32'(bus.wb_valid), 32'd0);
    chk({tag, " redirect_PC"}, bus.redirect_PC, 32'd0);
    chk({tag, " wb_rd"},       32'(bus.wb_rd), 32'd0);
    chk({tag, " wb_data"},     bus.wb_data, 32'd0);
    chk({tag, " branch_cnt"},  32'(bus.branch_cnt), 32'd0);
    chk({tag, " taken_cnt"},   32'(bus.taken_cnt), 32'd0);
    chk({tag, " state"},       32'(bus.dbg_state), 32'd0);
  endtask

  // Issues one instruction and lets the jump unit finish after fin_delay idle WAIT cycles.
  task automatic run_vec(input vec_t v, input int fin_delay, input string tag);
    bus.issue_en        = 1'b1;
    bus.issue_is_branch = v.is_branch;
    bus.issue_rd        = v.rd;
    step();
    bus.issue_en        = 1'b0;
    bus.issue_is_branch = 1'b0;
    bus.issue_rd        = 5'd0;
    chk({tag, " busy after issue"}, 32'(bus.busy), 32'd1);
    chk({tag, " state WAIT"}, 32'(bus.dbg_state), 32'd1);
    for (int i = 0; i < fin_delay; i++) begin
      step();
      chk({tag, " state held WAIT"}, 32'(bus.dbg_state), 32'd1);
      chk({tag, " no early redirect"}, 32'(bus.redirect), 32'd0);
    end
    bus.fu_finish  = 1'b1;
    bus.fu_cmp_res = v.cmp;
    bus.fu_PC_jump = v.pc_jump;
    bus.fu_PC_wb   = v.pc_wb;
    step();
    bus.fu_finish  = 1'b0;
    bus.fu_cmp_res = 1'b0;
    bus.fu_PC_jump = 32'hdead_beef;
    bus.fu_PC_wb   = 32'hdead_beef;
    bus.wb_ready   = 1'b0;
    chk({tag, " state RESOLVE"}, 32'(bus.dbg_state), 32'd2);
    chk({tag, " redirect low in RESOLVE"}, 32'(bus.redirect), 32'd0);
    chk({tag, " busy in RESOLVE"}, 32'(bus.busy), 32'd1);
    step();
    if (v.is_branch) begin
      exp_branch = exp_branch + 1'b1;
      exp_taken  = exp_taken + CNT_W'(v.cmp);
    end
    chk({tag, " redirect"}, 32'(bus.redirect), 32'(v.exp_redirect));
    chk({tag, " misalign"}, 32'(bus.misalign), 32'(v.exp_misalign));
    chk({tag, " branch_cnt"}, 32'(bus.branch_cnt), 32'(exp_branch));
    chk({tag, " taken_cnt"}, 32'(bus.taken_cnt), 32'(exp_taken));
    chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'(v.exp_wb));
    if (v.exp_redirect) chk({tag, " redirect_PC"}, bus.redirect_PC, v.pc_jump);
    if (v.exp_wb) begin
      chk({tag, " wb_rd"}, 32'(bus.wb_rd), 32'(v.rd));
      chk({tag, " wb_data"}, bus.wb_data, v.pc_wb);
      for (int i = 0; i < v.wait_cyc; i++) begin
        bus.wb_ready = 1'b0;
        step();
        chk({tag, " wb_valid held"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, " wb_rd held"}, 32'(bus.wb_rd), 32'(v.rd));
        chk({tag, " wb_data held"}, bus.wb_data, v.pc_wb);
        chk({tag, " busy in WB"}, 32'(bus.busy), 32'd1);
        chk({tag, " redirect one cycle"}, 32'(bus.redirect), 32'd0);
      end
      bus.wb_ready = 1'b1;
      step();
      bus.wb_ready = 1'b0;
    end else begin
      step();
    end
    chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
    chk({tag, " redirect end"}, 32'(bus.redirect), 32'd0);
    chk({tag, " misalign end"}, 32'(bus.misalign), 32'd0);
    chk({tag, " wb_valid end"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, " state IDLE"}, 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_branch = '0;
    exp_taken  = '0;
    //         br    rd     cmp   pc_jump       pc_wb         wait redir mis   wb
    vecs[0] = '{1'b0, 5'd1, 1'b0, 32'h0000_0100, 32'h0000_0024, 0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd7, 1'b0, 32'h0000_0080, 32'h0000_0030, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd7, 1'b1, 32'h0000_0040, 32'h0000_0034, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd3, 1'b0, 32'h0000_2000, 32'h0000_1004, 5, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 5'd0, 1'b0, 32'h0000_0200, 32'h0000_0008, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd9, 1'b1, 32'h0000_0102, 32'h0000_0050, 0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 5'd5, 1'b0, 32'h0000_0303, 32'h0000_0060, 0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'd2, 1'b0, 32'h0000_0102, 32'h0000_0070, 0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.issue_en = 1'b0;
    bus.issue_is_branch = 1'b0;
    bus.issue_rd = 5'd0;
    bus.fu_finish = 1'b0;
    bus.fu_cmp_res = 1'b0;
    bus.fu_PC_jump = 32'd0;
    bus.fu_PC_wb = 32'd0;
    bus.wb_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // A stray finish while idle must not start anything.
    bus.fu_finish = 1'b1;
    bus.fu_PC_jump = 32'h0000_0400;
    step();
    bus.fu_finish = 1'b0;
    step();
    chk("idle finish busy", 32'(bus.busy), 32'd0);
    chk("idle finish redirect", 32'(bus.redirect), 32'd0);
    chk("idle finish state", 32'(bus.dbg_state), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Late finish: several idle cycles spent in WAIT.
    run_vec(vecs[0], 3, "late_finish");

    // Reset while waiting for the jump unit.
    bus.issue_en = 1'b1;
    bus.issue_is_branch = 1'b0;
    bus.issue_rd = 5'd1;
    step();
    bus.issue_en = 1'b0;
    rst = 1'b1;
    bus.fu_finish = 1'b1;
    bus.fu_PC_jump = 32'h0000_0100;
    step();
    rst = 1'b0;
    bus.fu_finish = 1'b0;
    exp_branch = '0;
    exp_taken  = '0;
    check_reset_outputs("rst_wait");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_wait no redirect", 32'(bus.redirect), 32'd0);
      chk("rst_wait no wb", 32'(bus.wb_valid), 32'd0);
      chk("rst_wait idle", 32'(bus.busy), 32'd0);
    end

    // Reset while a link writeback is pending.
    run_vec(vecs[2], 0, "pre_wb");
    bus.issue_en = 1'b1;
    bus.issue_is_branch = 1'b0;
    bus.issue_rd = 5'd2;
    step();
    bus.issue_en = 1'b0;
    bus.fu_finish = 1'b1;
    bus.fu_PC_jump = 32'h0000_0040;
    bus.fu_PC_wb = 32'h0000_0044;
    step();
    bus.fu_finish = 1'b0;
    bus.wb_ready = 1'b0;
    step();
    chk("rst_wb wb_valid before", 32'(bus.wb_valid), 32'd1);
    chk("rst_wb state WB", 32'(bus.dbg_state), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_branch = '0;
    exp_taken  = '0;
    check_reset_outputs("rst_wb");
    step();
    chk("rst_wb no redirect", 32'(bus.redirect), 32'd0);
    chk("rst_wb no wb", 32'(bus.wb_valid), 32'd0);
    run_vec(vecs[0], 0, "post_rst");

    // 17 taken branches wrap a 4-bit counter to 1.
    tb_vec = '{1'b1, 5'd4, 1'b1, 32'h0000_0040, 32'h0000_0044, 0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) run_vec(tb_vec, 0, $sformatf("wrap%0d", i));
    chk("wrap branch_cnt", 32'(bus.branch_cnt), 32'd1);
    chk("wrap taken_cnt", 32'(bus.taken_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
